imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter WORDS, default 256, meaning the instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default 8, meaning the word-address width; WORDS equals 2**AW.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  meaning begin a load session; sampled in IDLE, DONE and ERR only.
REQ-006 SHALL have port len  input  AW+1  meaning the number of words to load; latched when start is accepted.
REQ-007 SHALL have port byte_valid  input  1  meaning the host offers byte_data.
REQ-008 SHALL have port byte_data  input  8  meaning the program byte; the stream is little-endian within each word.
REQ-009 SHALL have port byte_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-010 SHALL have port im_we  output  1  meaning the instruction-memory write strobe.
REQ-011 SHALL have port im_addr  output  AW  meaning the word index written.
REQ-012 SHALL have port im_wdata  output  32  meaning the assembled instruction word.
REQ-013 SHALL have port core_rst_n  output  1  meaning the active-low reset to the processor core.
REQ-014 SHALL have outputs busy, done and err, each 1 bit, meaning session status.
REQ-015 SHALL have output words_loaded  AW+1  meaning the count of words written in the current session.
REQ-016 SHALL have output csum  32  meaning the XOR of all words written in the current session.

Function
REQ-017 SHALL implement states IDLE, LOAD, WRITE, DONE and ERR.
REQ-018 SHALL go from IDLE, DONE or ERR on start=1 to LOAD if 1<=len<=WORDS, otherwise to ERR; in both cases it clears words_loaded, csum and the byte index.
REQ-019 SHALL drive byte_ready=1 only in LOAD; a byte transfers on a rising edge where byte_valid and byte_ready are both 1.
REQ-020 SHALL place the k-th accepted byte of a word (k=0..3) in im_wdata bits [8k+7:8k].
REQ-021 SHALL move LOAD->WRITE on the edge accepting byte 3; in WRITE, im_we=1 for exactly one cycle with im_addr=words_loaded[AW-1:0].
REQ-022 SHALL, on leaving WRITE, increment words_loaded, XOR the word into csum, and go to DONE if the new count equals len, else to LOAD.
REQ-023 SHALL hold byte_ready=0 during WRITE (one bubble cycle per word; best case 5 cycles per word).
REQ-024 SHALL hold all state in LOAD while byte_valid=0, with no timeout.
REQ-025 SHALL drive core_rst_n=1 only in DONE; it is 0 in IDLE, LOAD, WRITE and ERR.
REQ-026 SHALL drive busy=1 in LOAD and WRITE, done=1 in DONE and err=1 in ERR; all outputs are registered or decoded from state only.
REQ-027 SHALL ignore start in LOAD and WRITE.
REQ-028 SHALL reassert core_rst_n=0 on the cycle after a restart from DONE is accepted.
REQ-029 SHALL hold im_wdata stable outside WRITE; its value there is don't-care but must not change during WRITE.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state IDLE, core_rst_n=0, im_we=0, byte_ready=0, busy=done=err=0, words_loaded=0, csum=0, im_addr=0, im_wdata=0 and byte index 0.
REQ-031 SHALL, on reset assertion mid-session, discard any partially assembled word and never write it.

Verification
REQ-032 SHALL pass: start, len=2, continuous bytes 13 00 00 00 93 00 10 00 -> im_we pulses at addr 0 with 0x00000013, then at addr 1 with 0x00100093; done=1; words_loaded=2; csum=0x00100080; core_rst_n rises the cycle done rises.
REQ-033 SHALL pass: start, len=0 and separately len=WORDS+1 -> ERR, err=1, no im_we, core_rst_n stays 0.
REQ-034 SHALL pass: byte_valid toggling 1/0 every cycle, len=1 -> the word is still written exactly once; byte_ready is 0 during WRITE.
REQ-035 SHALL pass: rst_n pulsed low after 2 bytes of the first word -> no im_we; all outputs at reset values; a following start/len=1 loads a clean word at addr 0.
REQ-036 SHALL pass: len=WORDS full load -> last write at addr WORDS-1, words_loaded=WORDS; then start with len=1 -> core_rst_n drops the next cycle and addr 0 is rewritten.
REQ-037 SHALL pass: start asserted during LOAD -> no effect on counters, byte index or state.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
// master: the loader (consumes host bytes, drives memory writes).
// slave:  the environment (host byte source plus instruction memory).
interface imem_loader_if #(
    parameter int AW = 8
) ();
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to consecutive word addresses, keeps a running
// XOR checksum and releases the core from reset once the whole image is in.
module imem_loader #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW:0]       len,
    imem_loader_if.master     bus,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW:0]       words_loaded,
    output logic [31:0]       csum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    // Maximum legal length expressed at the width of len.
    localparam logic [AW:0] MAX_LEN = (AW+1)'(WORDS);

    logic [2:0]  r_state;
    logic [AW:0] r_len;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_asm;        // bytes 0..2 of the word being assembled
    logic [31:0] r_wdata;      // complete word, only updated on byte 3
    logic [AW:0] r_words;
    logic [31:0] r_csum;

    logic        w_idle_like;
    logic        w_start_acc;
    logic        w_len_ok;
    logic        w_byte_acc;
    logic        w_last_byte;
    logic [AW:0] w_words_inc;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_start_acc = w_idle_like && start;
    assign w_len_ok    = (len != '0) && (len <= MAX_LEN);
    assign w_byte_acc  = (r_state == S_LOAD) && bus.byte_valid;
    assign w_last_byte = w_byte_acc && (r_byte_idx == 2'd3);
    assign w_words_inc = r_words + {{AW{1'b0}}, 1'b1};

    // Session state machine; start is only honoured while not loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_len   <= len;
                        r_state <= w_len_ok ? S_LOAD : S_ERR;
                    end
                end
                S_LOAD: begin
                    if (w_last_byte) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_state <= (w_words_inc == r_len) ? S_DONE : S_LOAD;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte assembly; the finished word is published only when byte 3 lands so
    // im_wdata stays put everywhere except the edge entering WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_wdata    <= '0;
        end else if (w_start_acc) begin
            r_byte_idx <= '0;
        end else if (w_byte_acc) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
                r_wdata <= {bus.byte_data, r_asm};
            end else begin
                r_asm[{r_byte_idx, 3'b000} +: 8] <= bus.byte_data;
            end
        end
    end

    // Word counter and checksum, updated as the write cycle completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words <= '0;
            r_csum  <= '0;
        end else if (w_start_acc) begin
            r_words <= '0;
            r_csum  <= '0;
        end else if (r_state == S_WRITE) begin
            r_words <= w_words_inc;
            r_csum  <= r_csum ^ r_wdata;
        end
    end

    assign bus.byte_ready = (r_state == S_LOAD);
    assign bus.im_we      = (r_state == S_WRITE);
    assign bus.im_addr    = r_words[AW-1:0];
    assign bus.im_wdata   = r_wdata;

    assign core_rst_n   = (r_state == S_DONE);
    assign busy         = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done         = (r_state == S_DONE);
    assign err          = (r_state == S_ERR);
    assign words_loaded = r_words;
    assign csum         = r_csum;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized load sessions
// compared against a byte-list reference model of the expected writes.
module tb_imem_loader;

    localparam int WORDS = 256;
    localparam int AW    = 8;
    localparam int LW    = AW + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   len;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;
    logic [31:0]   csum;

    imem_loader_if #(.AW(AW)) bus_if ();

    imem_loader #(.WORDS(WORDS), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .bus          (bus_if.master),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded),
        .csum         (csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;
    int n_sess = 0;

    logic [7:0]    byte_q[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory-side monitor: records every write; the loader must never offer
    // to take a byte in the same cycle it writes.
    always @(negedge clk) begin
        if (rst_n && bus_if.im_we) begin
            got_addr.push_back(bus_if.im_addr);
            got_data.push_back(bus_if.im_wdata);
            wr_count++;
            chk("ready_in_write", 32'(bus_if.byte_ready), 32'd0);
        end
    end

    task automatic check_reset_vals(input string who);
        chk({who, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk({who, "_busy"},       32'(busy),       32'd0);
        chk({who, "_done"},       32'(done),       32'd0);
        chk({who, "_err"},        32'(err),        32'd0);
        chk({who, "_words"},      32'(words_loaded), 32'd0);
        chk({who, "_csum"},       csum,            32'd0);
        chk({who, "_im_we"},      32'(bus_if.im_we), 32'd0);
        chk({who, "_ready"},      32'(bus_if.byte_ready), 32'd0);
        chk({who, "_im_addr"},    32'(bus_if.im_addr), 32'd0);
        chk({who, "_im_wdata"},   bus_if.im_wdata, 32'd0);
    endtask

    task automatic fill_random(input int n);
        byte_q.delete();
        for (int i = 0; i < 4 * n; i++) byte_q.push_back(8'($urandom));
    endtask

    // One legal session: byte_q holds the image; mode 0 = continuous valid,
    // 1 = valid toggling each cycle, 2 = random gaps. poke throws stray start
    // pulses (with junk len) at the loader while it is busy.
    task automatic run_session(input int n, input int mode, input bit poke);
        logic [31:0] exp_w;
        logic [31:0] exp_csum;
        logic        v;
        int          bi;
        int          cyc;
        int          limit;
        got_addr.delete();
        got_data.delete();
        @(negedge clk);
        start = 1'b1;
        len   = LW'(n);
        @(negedge clk);
        start = 1'b0;
        chk("post_start_busy",     32'(busy),         32'd1);
        chk("post_start_core_rst", 32'(core_rst_n),   32'd0);
        chk("post_start_words",    32'(words_loaded), 32'd0);
        chk("post_start_csum",     csum,              32'd0);
        bi    = 0;
        cyc   = 0;
        limit = 20 * n + 50;
        while (!done && !err && cyc < limit) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (bi >= byte_q.size()) v = 1'b0;
            bus_if.byte_valid = v;
            bus_if.byte_data  = v ? byte_q[bi] : 8'h00;
            if (poke) begin
                start = ($urandom_range(0, 3) == 0);
                len   = LW'($urandom_range(0, 2 * WORDS - 1));
            end
            if (v && bus_if.byte_ready) bi++;
            @(negedge clk);
            cyc++;
            if (!done) chk("core_rst_while_busy", 32'(core_rst_n), 32'd0);
        end
        start = 1'b0;
        bus_if.byte_valid = 1'b0;
        chk("session_in_time", 32'(cyc < limit), 32'd1);
        chk("session_done",    32'(done),        32'd1);
        chk("session_core_rst",32'(core_rst_n),  32'd1);
        chk("session_err",     32'(err),         32'd0);
        chk("session_busy",    32'(busy),        32'd0);
        chk("write_count",     32'(got_addr.size()), 32'(n));
        exp_csum = 32'd0;
        for (int i = 0; i < n; i++) begin
            exp_w = {byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]};
            exp_csum = exp_csum ^ exp_w;
            if (i < got_addr.size()) begin
                chk("wr_addr", 32'(got_addr[i]), 32'(i % WORDS));
                chk("wr_data", got_data[i], exp_w);
            end
        end
        chk("words_loaded", 32'(words_loaded), 32'(n));
        chk("csum",         csum,              exp_csum);
        n_sess++;
        $display("session %0d: len=%0d mode=%0d poke=%0d writes=%0d csum=0x%08h",
                 n_sess, n, mode, poke, got_addr.size(), csum);
    endtask

    // Illegal length: must land in ERR without touching memory or the core.
    task automatic run_err(input int l);
        int w0;
        w0 = wr_count;
        @(negedge clk);
        start = 1'b1;
        len   = LW'(l);
        @(negedge clk);
        start = 1'b0;
        chk("err_flag",     32'(err),          32'd1);
        chk("err_busy",     32'(busy),         32'd0);
        chk("err_done",     32'(done),         32'd0);
        chk("err_core_rst", 32'(core_rst_n),   32'd0);
        chk("err_ready",    32'(bus_if.byte_ready), 32'd0);
        chk("err_words",    32'(words_loaded), 32'd0);
        repeat (4) @(negedge clk);
        chk("err_hold",     32'(err),          32'd1);
        chk("err_core_rst2",32'(core_rst_n),   32'd0);
        chk("err_no_write", 32'(wr_count - w0), 32'd0);
        $display("error session: len=%0d err=%0d", l, err);
    endtask

    initial begin
        int w0;
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("idle");

        // Two-instruction reference image.
        byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_session(2, 0, 1'b0);
        chk("ref_csum", csum, 32'h00100080);

        // Out-of-range lengths.
        run_err(0);
        run_err(WORDS + 1);

        // Stalling host, single word.
        fill_random(1);
        run_session(1, 1, 1'b0);

        // Reset pulse after two bytes of the first word.
        w0 = wr_count;
        @(negedge clk);
        start = 1'b1;
        len   = LW'(1);
        @(negedge clk);
        start = 1'b0;
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = 8'hAA;
        @(negedge clk);
        bus_if.byte_data  = 8'hBB;
        @(negedge clk);
        bus_if.byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_write", 32'(wr_count - w0), 32'd0);
        $display("reset-abort: writes during aborted session=%0d", wr_count - w0);
        fill_random(1);
        run_session(1, 0, 1'b0);

        // Full-depth image, then restart from DONE with a one-word image.
        fill_random(WORDS);
        run_session(WORDS, 2, 1'b0);
        fill_random(1);
        run_session(1, 2, 1'b0);

        // Stray start pulses while busy.
        fill_random(5);
        run_session(5, 2, 1'b1);

        // Randomized sessions.
        for (int s = 0; s < 6; s++) begin
            fill_random($urandom_range(1, 8));
            run_session(byte_q.size() / 4, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
